// File: rtl/fpu_reg_access_ctrl.sv
// FPU register-file access controller: issue decode, hazard scoreboard, one-entry
// dispatch register with writeback forwarding, and regfile write-port passthrough.
module fpu_reg_access_ctrl #(
  parameter int num_bits = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                iss_valid,
  output logic                iss_ready,
  input  logic [4:0]          iss_rs1,
  input  logic [4:0]          iss_rs2,
  input  logic [4:0]          iss_rd,
  input  logic                iss_wen,
  output logic [4:0]          rf_read_addr1,
  output logic [4:0]          rf_read_addr2,
  input  logic [num_bits-1:0] rf_read_data1,
  input  logic [num_bits-1:0] rf_read_data2,
  output logic [4:0]          rf_write_addr,
  output logic [num_bits-1:0] rf_write_data,
  output logic                rf_write_enable,
  output logic                dsp_valid,
  input  logic                dsp_ready,
  output logic [num_bits-1:0] dsp_op_a,
  output logic [num_bits-1:0] dsp_op_b,
  output logic [4:0]          dsp_rd,
  output logic                dsp_wen,
  input  logic                wb_valid,
  input  logic [4:0]          wb_rd,
  input  logic [num_bits-1:0] wb_data,
  output logic [31:0]         busy,
  output logic                err_spurious_wb
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} dsp_state_t;

  dsp_state_t          state_p1;
  logic [num_bits-1:0] op_a_p1;
  logic [num_bits-1:0] op_b_p1;
  logic [4:0]          rd_p1;
  logic                wen_p1;
  logic [31:0]         busy_p1;
  logic                err_p1;

  logic                fwd_rs1, fwd_rs2, fwd_rd;
  logic                hazard;
  logic                accept;
  logic [num_bits-1:0] op_a_p0, op_b_p0;
  logic [31:0]         busy_nxt;

  assign rf_read_addr1   = iss_rs1;
  assign rf_read_addr2   = iss_rs2;
  assign rf_write_addr   = wb_rd;
  assign rf_write_data   = wb_data;
  assign rf_write_enable = wb_valid;

  // The regfile commits a writeback one edge late, so a same-cycle result must be
  // forwarded both into the operands and past the scoreboard.
  assign fwd_rs1 = wb_valid && (wb_rd == iss_rs1);
  assign fwd_rs2 = wb_valid && (wb_rd == iss_rs2);
  assign fwd_rd  = wb_valid && (wb_rd == iss_rd);

  assign hazard = (busy_p1[iss_rs1] && !fwd_rs1) ||
                  (busy_p1[iss_rs2] && !fwd_rs2) ||
                  (iss_wen && busy_p1[iss_rd] && !fwd_rd);

  assign iss_ready = !hazard && ((state_p1 == EMPTY) || dsp_ready);
  assign accept    = iss_valid && iss_ready;

  assign op_a_p0 = fwd_rs1 ? wb_data : rf_read_data1;
  assign op_b_p0 = fwd_rs2 ? wb_data : rf_read_data2;

  // Clear before set so a register retired and re-claimed in one cycle stays busy.
  always_comb begin
    busy_nxt = busy_p1;
    if (wb_valid)          busy_nxt[wb_rd]  = 1'b0;
    if (accept && iss_wen) busy_nxt[iss_rd] = 1'b1;
  end

  // ---- stage p0 -> p1: dispatch register, scoreboard and error flag ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_p1 <= EMPTY;
      op_a_p1  <= '0;
      op_b_p1  <= '0;
      rd_p1    <= '0;
      wen_p1   <= 1'b0;
      busy_p1  <= '0;
      err_p1   <= 1'b0;
    end else begin
      case (state_p1)
        EMPTY: begin
          if (accept) begin
            state_p1 <= FULL;
            op_a_p1  <= op_a_p0;
            op_b_p1  <= op_b_p0;
            rd_p1    <= iss_rd;
            wen_p1   <= iss_wen;
          end
        end
        FULL: begin
          if (accept) begin
            op_a_p1 <= op_a_p0;
            op_b_p1 <= op_b_p0;
            rd_p1   <= iss_rd;
            wen_p1  <= iss_wen;
          end else if (dsp_ready) begin
            state_p1 <= EMPTY;
          end
        end
        default: state_p1 <= EMPTY;
      endcase
      busy_p1 <= busy_nxt;
      if (wb_valid && !busy_p1[wb_rd]) err_p1 <= 1'b1;
    end
  end

  assign dsp_valid       = (state_p1 == FULL);
  assign dsp_op_a        = op_a_p1;
  assign dsp_op_b        = op_b_p1;
  assign dsp_rd          = rd_p1;
  assign dsp_wen         = wen_p1;
  assign busy            = busy_p1;
  assign err_spurious_wb = err_p1;

endmodule
